// File: rtl/tbird_light_seq.sv
// Thunderbird tail-light sequencer: switch requests become left/right/hazard lamp
// sequences stepped on a prescaled tick, optionally latched to the display on frame_start.
module tbird_light_seq #(
    parameter int unsigned TICK_DIV     = 12_500_000,
    parameter bit          DISPLAY_SYNC = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    input  logic       frame_start,
    output logic [5:0] LEDs,
    output logic       tick,
    output logic       busy
);
    // state  | meaning
    // IDLE   | all lamps dark, waiting for a request
    // L1..L3 | left sequence, 1..3 lamps lit outward
    // R1..R3 | right sequence, 1..3 lamps lit outward
    // HZ_ON  | hazard flash, all lamps lit
    // HZ_OFF | hazard flash, all lamps dark
    typedef enum logic [3:0] {
        IDLE, L1, L2, L3, R1, R2, R3, HZ_ON, HZ_OFF
    } state_t;

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sync1_q, sync2_q;
    logic [5:0]    pending_q, pending_d;
    logic [5:0]    leds_q, leds_d;
    logic          haz, lft, rgt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            pending_q <= '0;
            leds_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= {hazard, left, right};
            sync2_q   <= sync1_q;
            pending_q <= pending_d;
            leds_q    <= leds_d;
        end
    end

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    // Both switches together are treated as a hazard request.
    assign haz = sync2_q[2] | (sync2_q[1] & sync2_q[0]);
    assign lft = sync2_q[1] & ~haz;
    assign rgt = sync2_q[0] & ~haz;

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                IDLE:   state_d = haz ? HZ_ON : lft ? L1 : rgt ? R1 : IDLE;
                L1:     state_d = haz ? HZ_ON : lft ? L2 : IDLE;
                L2:     state_d = haz ? HZ_ON : lft ? L3 : IDLE;
                L3:     state_d = haz ? HZ_ON : IDLE;
                R1:     state_d = haz ? HZ_ON : rgt ? R2 : IDLE;
                R2:     state_d = haz ? HZ_ON : rgt ? R3 : IDLE;
                R3:     state_d = haz ? HZ_ON : IDLE;
                HZ_ON:  state_d = HZ_OFF;
                HZ_OFF: state_d = haz ? HZ_ON : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pending_d = 6'b000000;
        unique case (state_q)
            L1:      pending_d = 6'b001000;
            L2:      pending_d = 6'b011000;
            L3:      pending_d = 6'b111000;
            R1:      pending_d = 6'b000100;
            R2:      pending_d = 6'b000110;
            R3:      pending_d = 6'b000111;
            HZ_ON:   pending_d = 6'b111111;
            default: pending_d = 6'b000000;
        endcase
    end

    // A step landing with frame_start loads the old pending; the new one waits a frame.
    always_comb begin
        leds_d = leds_q;
        if (!DISPLAY_SYNC || frame_start) leds_d = pending_q;
    end

    assign LEDs = leds_q;
    assign busy = (state_q != IDLE);

endmodule
